rf_read_arb: RTL and testbench

Arbiter and sequencer for the two general-register-file read ports, shared between the decode stage and the debug unit. In normal operation the decode stage's read requests pass straight through to the register file. On a debug read request, the arbiter:
- asks the pipeline controller to stall,
- waits for the freeze,
- borrows read port 1 for one cycle,
- returns the data with a one-cycle acknowledge.

It sits between `id`, `regfile`, `ctrl` and the debug unit.

---
 rtl/rf_read_arb_pkg.sv | 16 +
 rtl/rf_arb_timer.sv | 39 +++
 rtl/rf_read_arb.sv | 151 +++++++++++++++
 tb/tb_rf_read_arb.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_read_arb_pkg.sv
// Shared constants for the register-file read arbiter: reset/read levels,
// null values and the 2-bit arbiter state encodings.
package rf_read_arb_pkg;

  localparam logic        RstEnable   = 1'b1;
  localparam logic        ReadEnable  = 1'b1;
  localparam logic        ReadDisable = 1'b0;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr  = 5'b00000;

  localparam logic [1:0]  RFARB_IDLE  = 2'd0;
  localparam logic [1:0]  RFARB_STALL = 2'd1;
  localparam logic [1:0]  RFARB_GRANT = 2'd2;
  localparam logic [1:0]  RFARB_DONE  = 2'd3;

endpackage

// File: rtl/rf_arb_timer.sv
// Stall-wait timeout counter: cleared on stall entry, counts cycles without freeze.
// term_o fires on the increment that brings the count to all-ones.
module rf_arb_timer
  import rf_read_arb_pkg::*;
#(
  parameter int TIMEOUT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic cnt_en_i,
  output logic term_o
);

  localparam logic [TIMEOUT_W-1:0] CntLast = ~TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] cnt_q;
  logic [TIMEOUT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_en_i) begin
      cnt_d = cnt_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = cnt_en_i && (cnt_q == CntLast);

endmodule

// File: rtl/rf_read_arb.sv
// Shares regfile read port 1 between decode and debug; a debug read stalls the pipe,
// borrows port 1 for one frozen cycle and acks. RF_ARB_TIMEOUT_EN adds a stall-wait timeout.
module rf_read_arb
  import rf_read_arb_pkg::*;
#(
  parameter int TIMEOUT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_reg1_read_i,
  input  logic [4:0]  id_reg1_addr_i,
  input  logic        id_reg2_read_i,
  input  logic [4:0]  id_reg2_addr_i,
  output logic [31:0] id_reg1_data_o,
  output logic [31:0] id_reg2_data_o,
  output logic        rf_re1_o,
  output logic [4:0]  rf_raddr1_o,
  input  logic [31:0] rf_rdata1_i,
  output logic        rf_re2_o,
  output logic [4:0]  rf_raddr2_o,
  input  logic [31:0] rf_rdata2_i,
  input  logic        dbg_req_i,
  input  logic [4:0]  dbg_addr_i,
  output logic        dbg_ack_o,
  output logic [31:0] dbg_data_o,
  output logic        dbg_err_o,
  output logic        stallreq_o,
  input  logic        stall_i
);

  logic [1:0]  state_q, state_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        in_grant;

`ifdef RF_ARB_TIMEOUT_EN
  logic err_q, err_d;
  logic tmr_term;

  rf_arb_timer #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    ((state_q == RFARB_IDLE) && dbg_req_i),
    .cnt_en_i ((state_q == RFARB_STALL) && !stall_i),
    .term_o   (tmr_term)
  );
`else
  logic [31:0] unused_timeout_w;
  assign unused_timeout_w = 32'(TIMEOUT_W);
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef RF_ARB_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      RFARB_IDLE: begin
        if (dbg_req_i) begin
          state_d = RFARB_STALL;
          addr_d  = dbg_addr_i;
        end
      end
      RFARB_STALL: begin
        // A freeze arriving together with the terminal count still gets the read.
        if (stall_i) begin
          state_d = RFARB_GRANT;
        end
`ifdef RF_ARB_TIMEOUT_EN
        else if (tmr_term) begin
          state_d = RFARB_DONE;
          data_d  = ZeroWord;
          err_d   = 1'b1;
        end
`endif
      end
      RFARB_GRANT: begin
        state_d = RFARB_DONE;
        data_d  = rf_rdata1_i;
`ifdef RF_ARB_TIMEOUT_EN
        err_d   = 1'b0;
`endif
      end
      default: begin
        state_d = RFARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= RFARB_IDLE;
      addr_q  <= NOPRegAddr;
      data_q  <= ZeroWord;
`ifdef RF_ARB_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef RF_ARB_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

  assign in_grant = (state_q == RFARB_GRANT);

  always_comb begin
    rf_re1_o       = ReadDisable;
    rf_raddr1_o    = NOPRegAddr;
    rf_re2_o       = ReadDisable;
    rf_raddr2_o    = NOPRegAddr;
    id_reg1_data_o = ZeroWord;
    id_reg2_data_o = ZeroWord;
    if (rst != RstEnable) begin
      rf_re2_o    = id_reg2_read_i;
      rf_raddr2_o = id_reg2_addr_i;
      if (id_reg2_read_i) begin
        id_reg2_data_o = rf_rdata2_i;
      end
      // Decode never sees port 1 data while debug owns it; the pipe is frozen anyway.
      if (in_grant) begin
        rf_re1_o    = ReadEnable;
        rf_raddr1_o = addr_q;
      end else begin
        rf_re1_o    = id_reg1_read_i;
        rf_raddr1_o = id_reg1_addr_i;
        if (id_reg1_read_i) begin
          id_reg1_data_o = rf_rdata1_i;
        end
      end
    end
  end

  assign stallreq_o = (rst != RstEnable) &&
                      ((state_q == RFARB_STALL) || (state_q == RFARB_GRANT));
  assign dbg_ack_o  = (rst != RstEnable) && (state_q == RFARB_DONE);
  assign dbg_data_o = data_q;
`ifdef RF_ARB_TIMEOUT_EN
  assign dbg_err_o  = dbg_ack_o && err_q;
`else
  assign dbg_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_rf_read_arb.sv
// Directed bench for rf_read_arb: pass-through, debug read latency, delayed freeze,
// timeout (RF_ARB_TIMEOUT_EN) or indefinite wait, reset mid-grant and back-to-back reads.
module tb_rf_read_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_reg1_read_i, id_reg2_read_i;
  logic [4:0]  id_reg1_addr_i, id_reg2_addr_i;
  logic [31:0] id_reg1_data_o, id_reg2_data_o;
  logic        rf_re1_o, rf_re2_o;
  logic [4:0]  rf_raddr1_o, rf_raddr2_o;
  logic [31:0] rf_rdata1_i, rf_rdata2_i;
  logic        dbg_req_i;
  logic [4:0]  dbg_addr_i;
  logic        dbg_ack_o, dbg_err_o, stallreq_o, stall_i;
  logic [31:0] dbg_data_o;

  logic [31:0] regs [32];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign rf_rdata1_i = regs[rf_raddr1_o];
  assign rf_rdata2_i = regs[rf_raddr2_o];

  rf_read_arb #(.TIMEOUT_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_reg1_read_i (id_reg1_read_i),
    .id_reg1_addr_i (id_reg1_addr_i),
    .id_reg2_read_i (id_reg2_read_i),
    .id_reg2_addr_i (id_reg2_addr_i),
    .id_reg1_data_o (id_reg1_data_o),
    .id_reg2_data_o (id_reg2_data_o),
    .rf_re1_o       (rf_re1_o),
    .rf_raddr1_o    (rf_raddr1_o),
    .rf_rdata1_i    (rf_rdata1_i),
    .rf_re2_o       (rf_re2_o),
    .rf_raddr2_o    (rf_raddr2_o),
    .rf_rdata2_i    (rf_rdata2_i),
    .dbg_req_i      (dbg_req_i),
    .dbg_addr_i     (dbg_addr_i),
    .dbg_ack_o      (dbg_ack_o),
    .dbg_data_o     (dbg_data_o),
    .dbg_err_o      (dbg_err_o),
    .stallreq_o     (stallreq_o),
    .stall_i        (stall_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    id_reg1_read_i = 1'b1; id_reg1_addr_i = 5'd5;
    id_reg2_read_i = 1'b1; id_reg2_addr_i = 5'd6;
    dbg_req_i = 1'b1; dbg_addr_i = 5'd3; stall_i = 1'b1;
    tick(); tick();
    total++; if (rf_re1_o !== 1'b0) begin bad++; $display("FAIL rst_re1: got %b want 0", rf_re1_o); end
    total++; if (rf_re2_o !== 1'b0) begin bad++; $display("FAIL rst_re2: got %b want 0", rf_re2_o); end
    total++; if (rf_raddr1_o !== 5'd0) begin bad++; $display("FAIL rst_raddr1: got %0d want 0", rf_raddr1_o); end
    total++; if (rf_raddr2_o !== 5'd0) begin bad++; $display("FAIL rst_raddr2: got %0d want 0", rf_raddr2_o); end
    total++; if (id_reg1_data_o !== 32'h0) begin bad++; $display("FAIL rst_id1: got %h want 0", id_reg1_data_o); end
    total++; if (id_reg2_data_o !== 32'h0) begin bad++; $display("FAIL rst_id2: got %h want 0", id_reg2_data_o); end
    total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL rst_stallreq: got %b want 0", stallreq_o); end
    total++; if (dbg_ack_o !== 1'b0) begin bad++; $display("FAIL rst_ack: got %b want 0", dbg_ack_o); end
    total++; if (dbg_err_o !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", dbg_err_o); end
    total++; if (dbg_data_o !== 32'h0) begin bad++; $display("FAIL rst_data: got %h want 0", dbg_data_o); end
    dbg_req_i = 1'b0;
    stall_i = 1'b0;
  endtask

  task automatic test_passthrough();
    rst = 1'b0;
    tick();
    total++; if (rf_re1_o !== 1'b1) begin bad++; $display("FAIL pt_re1: got %b want 1", rf_re1_o); end
    total++; if (rf_raddr1_o !== 5'd5) begin bad++; $display("FAIL pt_raddr1: got %0d want 5", rf_raddr1_o); end
    total++; if (id_reg1_data_o !== 32'h1234_5678) begin bad++; $display("FAIL pt_id1: got %h want 12345678", id_reg1_data_o); end
    total++; if (id_reg2_data_o !== 32'hA5A5_0006) begin bad++; $display("FAIL pt_id2: got %h want a5a50006", id_reg2_data_o); end
    total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL pt_stallreq: got %b want 0", stallreq_o); end
    id_reg1_read_i = 1'b0;
    #1;
    total++; if (id_reg1_data_o !== 32'h0) begin bad++; $display("FAIL pt_gate1: got %h want 0", id_reg1_data_o); end
    total++; if (rf_re1_o !== 1'b0) begin bad++; $display("FAIL pt_gate_re1: got %b want 0", rf_re1_o); end
    id_reg2_read_i = 1'b0;
    #1;
    total++; if (id_reg2_data_o !== 32'h0) begin bad++; $display("FAIL pt_gate2: got %h want 0", id_reg2_data_o); end
    id_reg1_read_i = 1'b1;
    id_reg2_read_i = 1'b1;
    #1;
  endtask

  task automatic test_dbg_read();
    stall_i = 1'b1; dbg_addr_i = 5'd3; dbg_req_i = 1'b1;
    tick();
    total++; if (stallreq_o !== 1'b1) begin bad++; $display("FAIL rd_stall_sr: got %b want 1", stallreq_o); end
    total++; if (dbg_ack_o !== 1'b0) begin bad++; $display("FAIL rd_stall_ack: got %b want 0", dbg_ack_o); end
    total++; if (rf_raddr1_o !== 5'd5) begin bad++; $display("FAIL rd_stall_raddr1: got %0d want 5", rf_raddr1_o); end
    total++; if (id_reg1_data_o !== 32'h1234_5678) begin bad++; $display("FAIL rd_stall_id1: got %h want 12345678", id_reg1_data_o); end
    tick();
    total++; if (stallreq_o !== 1'b1) begin bad++; $display("FAIL rd_grant_sr: got %b want 1", stallreq_o); end
    total++; if (rf_re1_o !== 1'b1) begin bad++; $display("FAIL rd_grant_re1: got %b want 1", rf_re1_o); end
    total++; if (rf_raddr1_o !== 5'd3) begin bad++; $display("FAIL rd_grant_raddr1: got %0d want 3", rf_raddr1_o); end
    total++; if (id_reg1_data_o !== 32'h0) begin bad++; $display("FAIL rd_grant_id1: got %h want 0", id_reg1_data_o); end
    total++; if (id_reg2_data_o !== 32'hA5A5_0006) begin bad++; $display("FAIL rd_grant_id2: got %h want a5a50006", id_reg2_data_o); end
    total++; if (dbg_ack_o !== 1'b0) begin bad++; $display("FAIL rd_grant_ack: got %b want 0", dbg_ack_o); end
    tick();
    total++; if (dbg_ack_o !== 1'b1) begin bad++; $display("FAIL rd_done_ack: got %b want 1", dbg_ack_o); end
    total++; if (dbg_data_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_done_data: got %h want deadbeef", dbg_data_o); end
    total++; if (dbg_err_o !== 1'b0) begin bad++; $display("FAIL rd_done_err: got %b want 0", dbg_err_o); end
    total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL rd_done_sr: got %b want 0", stallreq_o); end
    total++; if (rf_raddr1_o !== 5'd5) begin bad++; $display("FAIL rd_done_raddr1: got %0d want 5", rf_raddr1_o); end
    dbg_req_i = 1'b0;
    tick();
    total++; if (dbg_ack_o !== 1'b0) begin bad++; $display("FAIL rd_idle_ack: got %b want 0", dbg_ack_o); end
    total++; if (dbg_data_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_hold_data: got %h want deadbeef", dbg_data_o); end
    stall_i = 1'b0;
  endtask

  task automatic test_delayed_stall();
    int sr_cnt = 0;
    int ack_at = 0;
    stall_i = 1'b0; dbg_addr_i = 5'd7; dbg_req_i = 1'b1;
    tick();
    for (int k = 1; k <= 20; k++) begin
      if (stallreq_o === 1'b1) sr_cnt++;
      total++; if (id_reg2_data_o !== 32'hA5A5_0006) begin bad++; $display("FAIL dl_p2_c%0d: got %h want a5a50006", k, id_reg2_data_o); end
      if (dbg_ack_o === 1'b1 && ack_at == 0) begin
        ack_at = k;
        dbg_req_i = 1'b0;
        total++; if (dbg_data_o !== 32'hCAFE_F00D) begin bad++; $display("FAIL dl_data: got %h want cafef00d", dbg_data_o); end
        total++; if (dbg_err_o !== 1'b0) begin bad++; $display("FAIL dl_err: got %b want 0", dbg_err_o); end
      end
      if (k == 5) stall_i = 1'b1;
      tick();
    end
    total++; if (sr_cnt != 6) begin bad++; $display("FAIL dl_sr_cycles: got %0d want 6", sr_cnt); end
    total++; if (ack_at != 7) begin bad++; $display("FAIL dl_ack_cycle: got %0d want 7", ack_at); end
    stall_i = 1'b0;
  endtask

  task automatic test_timeout();
    int sr_cnt = 0;
    int ack_at = 0;
    logic err_seen = 1'b0;
    logic [31:0] data_seen = 32'hFFFF_FFFF;
    stall_i = 1'b0; dbg_addr_i = 5'd3; dbg_req_i = 1'b1;
    tick();
    for (int k = 1; k <= 40; k++) begin
      if (stallreq_o === 1'b1) sr_cnt++;
      if (dbg_ack_o === 1'b1 && ack_at == 0) begin
        ack_at = k; err_seen = dbg_err_o; data_seen = dbg_data_o;
        dbg_req_i = 1'b0;
      end
      tick();
    end
`ifdef RF_ARB_TIMEOUT_EN
    total++; if (sr_cnt != 15) begin bad++; $display("FAIL to_sr_cycles: got %0d want 15", sr_cnt); end
    total++; if (ack_at != 16) begin bad++; $display("FAIL to_ack_cycle: got %0d want 16", ack_at); end
    total++; if (err_seen !== 1'b1) begin bad++; $display("FAIL to_err: got %b want 1", err_seen); end
    total++; if (data_seen !== 32'h0) begin bad++; $display("FAIL to_data: got %h want 0", data_seen); end
`else
    total++; if (ack_at != 0) begin bad++; $display("FAIL to_no_ack: got ack at %0d want none", ack_at); end
    total++; if (stallreq_o !== 1'b1) begin bad++; $display("FAIL to_sr_held: got %b want 1", stallreq_o); end
    total++; if (sr_cnt != 40) begin bad++; $display("FAIL to_sr_cycles: got %0d want 40", sr_cnt); end
    stall_i = 1'b1;
    for (int k = 1; k <= 5 && ack_at == 0; k++) begin
      tick();
      if (dbg_ack_o === 1'b1) begin
        ack_at = k; err_seen = dbg_err_o; data_seen = dbg_data_o;
        dbg_req_i = 1'b0;
      end
    end
    total++; if (ack_at != 2) begin bad++; $display("FAIL to_recover_ack: got %0d want 2", ack_at); end
    total++; if (err_seen !== 1'b0) begin bad++; $display("FAIL to_recover_err: got %b want 0", err_seen); end
    total++; if (data_seen !== 32'hDEAD_BEEF) begin bad++; $display("FAIL to_recover_data: got %h want deadbeef", data_seen); end
    dbg_req_i = 1'b0;
    tick();
    stall_i = 1'b0;
`endif
  endtask

  task automatic test_reset_in_grant();
    int acks = 0;
    stall_i = 1'b1; dbg_addr_i = 5'd3; dbg_req_i = 1'b1;
    tick(); tick();
    total++; if (rf_raddr1_o !== 5'd3) begin bad++; $display("FAIL rg_grant_raddr1: got %0d want 3", rf_raddr1_o); end
    rst = 1'b1; dbg_req_i = 1'b0;
    #1;
    total++; if (rf_re1_o !== 1'b0) begin bad++; $display("FAIL rg_rst_re1: got %b want 0", rf_re1_o); end
    total++; if (rf_raddr1_o !== 5'd0) begin bad++; $display("FAIL rg_rst_raddr1: got %0d want 0", rf_raddr1_o); end
    total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL rg_rst_sr: got %b want 0", stallreq_o); end
    total++; if (id_reg2_data_o !== 32'h0) begin bad++; $display("FAIL rg_rst_id2: got %h want 0", id_reg2_data_o); end
    total++; if (dbg_ack_o !== 1'b0) begin bad++; $display("FAIL rg_rst_ack: got %b want 0", dbg_ack_o); end
    tick();
    rst = 1'b0;
    #1;
    total++; if (dbg_data_o !== 32'h0) begin bad++; $display("FAIL rg_data_cleared: got %h want 0", dbg_data_o); end
    total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL rg_idle_sr: got %b want 0", stallreq_o); end
    for (int k = 0; k < 4; k++) begin
      if (dbg_ack_o === 1'b1) acks++;
      tick();
    end
    total++; if (acks != 0) begin bad++; $display("FAIL rg_no_ack: got %0d acks want 0", acks); end
    dbg_addr_i = 5'd5; dbg_req_i = 1'b1;
    tick(); tick(); tick();
    total++; if (dbg_ack_o !== 1'b1) begin bad++; $display("FAIL rg_after_ack: got %b want 1", dbg_ack_o); end
    total++; if (dbg_data_o !== 32'h1234_5678) begin bad++; $display("FAIL rg_after_data: got %h want 12345678", dbg_data_o); end
    dbg_req_i = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    stall_i = 1'b1; dbg_addr_i = 5'd3; dbg_req_i = 1'b1;
    tick(); tick(); tick();
    total++; if (dbg_ack_o !== 1'b1) begin bad++; $display("FAIL bb_ack1: got %b want 1", dbg_ack_o); end
    total++; if (dbg_data_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bb_data1: got %h want deadbeef", dbg_data_o); end
    dbg_addr_i = 5'd6;
    tick();
    total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL bb_idle_sr: got %b want 0", stallreq_o); end
    total++; if (dbg_ack_o !== 1'b0) begin bad++; $display("FAIL bb_idle_ack: got %b want 0", dbg_ack_o); end
    tick();
    total++; if (stallreq_o !== 1'b1) begin bad++; $display("FAIL bb_stall_sr: got %b want 1", stallreq_o); end
    tick();
    total++; if (rf_raddr1_o !== 5'd6) begin bad++; $display("FAIL bb_grant_raddr1: got %0d want 6", rf_raddr1_o); end
    tick();
    total++; if (dbg_ack_o !== 1'b1) begin bad++; $display("FAIL bb_ack2: got %b want 1", dbg_ack_o); end
    total++; if (dbg_data_o !== 32'hA5A5_0006) begin bad++; $display("FAIL bb_data2: got %h want a5a50006", dbg_data_o); end
    dbg_req_i = 1'b0;
    tick();
    stall_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0100_0000 + 32'(i);
    regs[0] = 32'h0;
    regs[3] = 32'hDEAD_BEEF;
    regs[5] = 32'h1234_5678;
    regs[6] = 32'hA5A5_0006;
    regs[7] = 32'hCAFE_F00D;
    test_reset();
    test_passthrough();
    test_dbg_read();
    test_delayed_stall();
    test_timeout();
    test_reset_in_grant();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
